// File: rtl/key_sched_pkg.sv
// Shared types and constants for the keystream scheduler.
// The optional drop counter is enabled by KEY_SCHED_DROP_CNT_EN.
package key_sched_pkg;

    typedef enum logic [1:0] {
        GEN_RST = 2'd0,
        WARMUP  = 2'd1,
        RUN     = 2'd2
    } state_t;

    localparam int KEY_W          = 24;
    localparam int GEN_RST_CYCLES = 2;
    localparam int DROP_CNT_W     = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + DROP_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Synchronous FIFO for key triples; a push and a pop in the same cycle are
// both accepted when full, so the occupancy stays unchanged.
module key_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);
    assign rdata     = mem_r[rd_ptr_r];

    // Storage array; contents need no reset since the count guards reads.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap freely.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/key_scheduler.sv
// Sequences generator reset/warm-up, buffers key triples and grants them
// round-robin. Define KEY_SCHED_DROP_CNT_EN to build the drop counter.
module key_scheduler
    import key_sched_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int WARMUP_BYTES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  gen_rst,
    input  logic                  gen_key_ready,
    input  logic [7:0]            gen_r,
    input  logic [7:0]            gen_g,
    input  logic [7:0]            gen_b,
    input  logic                  reseed_req,
    output logic                  reseed_ack,
    input  logic [NREQ-1:0]       req,
    output logic [NREQ-1:0]       gnt,
    output logic                  key_valid,
    output logic [KEY_W-1:0]      key_rgb,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int IDX_W = (NREQ > 2) ? 2 : 1;

    state_t            state_r;
    state_t            state_next_s;
    logic [1:0]        rst_cnt_r;
    logic [3:0]        warm_cnt_r;
    logic              gen_rst_r;
    logic              reseed_pend_r;
    logic              reseed_ack_r;
    logic              enter_run_s;
    logic [NREQ-1:0]   gnt_r;
    logic              key_valid_r;
    logic [KEY_W-1:0]  key_rgb_r;
    logic [IDX_W-1:0]  last_r;
    logic [IDX_W-1:0]  winner_s;
    logic              found_s;
    logic              pop_s;
    logic              push_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [KEY_W-1:0]  fifo_rdata_s;

    assign gen_rst    = gen_rst_r;
    assign reseed_ack = reseed_ack_r;
    assign gnt        = gnt_r;
    assign key_valid  = key_valid_r;
    assign key_rgb    = key_rgb_r;

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= GEN_RST;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a zero warm-up length skips WARMUP entirely.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            GEN_RST: begin
                if (rst_cnt_r == 2'(GEN_RST_CYCLES - 1)) begin
                    state_next_s = (WARMUP_BYTES == 0) ? RUN : WARMUP;
                end else begin
                    state_next_s = GEN_RST;
                end
            end
            WARMUP: begin
                if (gen_key_ready && (warm_cnt_r == 4'(WARMUP_BYTES - 1))) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = WARMUP;
                end
            end
            RUN: begin
                if (reseed_req) begin
                    state_next_s = GEN_RST;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: state_next_s = GEN_RST;
        endcase
    end

    assign enter_run_s = (state_r != RUN) && (state_next_s == RUN);

    // Reset-pulse and warm-up counters; both restart on every generator reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_cnt_r  <= 2'd0;
            warm_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                GEN_RST: begin
                    rst_cnt_r  <= rst_cnt_r + 2'd1;
                    warm_cnt_r <= 4'd0;
                end
                WARMUP: begin
                    rst_cnt_r <= 2'd0;
                    if (gen_key_ready) begin
                        warm_cnt_r <= warm_cnt_r + 4'd1;
                    end
                end
                default: begin
                    rst_cnt_r  <= 2'd0;
                    warm_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    // Generator reset and reseed handshake; power-on reset never acknowledges.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gen_rst_r     <= 1'b1;
            reseed_pend_r <= 1'b0;
            reseed_ack_r  <= 1'b0;
        end else begin
            gen_rst_r    <= (state_next_s == GEN_RST);
            reseed_ack_r <= enter_run_s && reseed_pend_r;
            if (state_r == RUN && reseed_req) begin
                reseed_pend_r <= 1'b1;
            end else if (enter_run_s) begin
                reseed_pend_r <= 1'b0;
            end
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        found_s  = 1'b0;
        winner_s = last_r;
        for (int i = 1; i <= NREQ; i++) begin
            int            cand;
            logic [IDX_W-1:0] idx;
            cand     = (int'(last_r) + i) % NREQ;
            idx      = cand[IDX_W-1:0];
            winner_s = (req[idx] && !found_s) ? idx : winner_s;
            found_s  = found_s | req[idx];
        end
    end

    assign pop_s  = (state_r == RUN) && !fifo_empty_s && found_s;
    assign push_s = (state_r == RUN) && gen_key_ready;

    // Registered grant; key_rgb holds its last value between transfers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gnt_r       <= {NREQ{1'b0}};
            key_valid_r <= 1'b0;
            key_rgb_r   <= {KEY_W{1'b0}};
            last_r      <= IDX_W'(NREQ - 1);
        end else if (pop_s) begin
            gnt_r       <= {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
            key_valid_r <= 1'b1;
            key_rgb_r   <= fifo_rdata_s;
            last_r      <= winner_s;
        end else begin
            gnt_r       <= {NREQ{1'b0}};
            key_valid_r <= 1'b0;
        end
    end

    key_fifo #(
        .W     (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (state_r == GEN_RST),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({gen_r, gen_g, gen_b}),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

`ifdef KEY_SCHED_DROP_CNT_EN
    logic                  drop_s;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    assign drop_s     = push_s && fifo_full_s && !pop_s;
    assign drop_count = drop_cnt_r;

    // Saturating count of triples rejected by a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else if (drop_s) begin
            drop_cnt_r <= sat_inc(drop_cnt_r);
        end
    end
`else
    assign drop_count = {DROP_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_key_scheduler.sv
// Directed self-checking bench for key_scheduler (NREQ=2, FIFO_DEPTH=4, WARMUP_BYTES=2).
module tb_key_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gen_key_ready = 1'b0;
    logic [7:0]  gen_r = 8'h00, gen_g = 8'h00, gen_b = 8'h00;
    logic        reseed_req = 1'b0;
    logic [1:0]  req = 2'b00;
    logic        gen_rst, reseed_ack, key_valid;
    logic [1:0]  gnt;
    logic [23:0] key_rgb;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

`ifdef KEY_SCHED_DROP_CNT_EN
    localparam logic [7:0] EXP_DROP = 8'd2;
`else
    localparam logic [7:0] EXP_DROP = 8'd0;
`endif

    key_scheduler #(.NREQ(2), .FIFO_DEPTH(4), .WARMUP_BYTES(2)) dut (
        .clk(clk), .rst_n(rst_n), .gen_rst(gen_rst), .gen_key_ready(gen_key_ready),
        .gen_r(gen_r), .gen_g(gen_g), .gen_b(gen_b), .reseed_req(reseed_req),
        .reseed_ack(reseed_ack), .req(req), .gnt(gnt), .key_valid(key_valid),
        .key_rgb(key_rgb), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input logic [23:0] k);
        {gen_r, gen_g, gen_b} = k;
        gen_key_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 2'b00;
        tick();
        checks++; if (gen_rst !== 1'b1) begin errors++; $display("FAIL rst_gen_rst got %b exp 1", gen_rst); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rst_key_valid got %b exp 0", key_valid); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b exp 00", gnt); end
        checks++; if (key_rgb !== 24'h0) begin errors++; $display("FAIL rst_key_rgb got %h exp 000000", key_rgb); end
        checks++; if (reseed_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", reseed_ack); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_count); end
        rst_n = 1'b1;
        checks++; if (gen_rst !== 1'b1) begin errors++; $display("FAIL gen_rst_c1 got %b exp 1", gen_rst); end
        tick();
        checks++; if (gen_rst !== 1'b1) begin errors++; $display("FAIL gen_rst_c2 got %b exp 1", gen_rst); end
        tick();
        checks++; if (gen_rst !== 1'b0) begin errors++; $display("FAIL gen_rst_c3 got %b exp 0", gen_rst); end
    endtask

    task automatic test_warmup_first_key();
        req = 2'b01;
        for (int i = 0; i < 2; i++) begin
            set_key(24'h111111);
            tick();
            gen_key_ready = 1'b0;
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL warmup_discard%0d got %b exp 0", i, key_valid); end
            repeat (7) tick();
        end
        set_key(24'hA5C33C);
        tick();
        gen_key_ready = 1'b0;
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL first_key_early got %b exp 0", key_valid); end
        tick();
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL first_key_valid got %b exp 1", key_valid); end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL first_key_gnt got %b exp 01", gnt); end
        checks++; if (key_rgb !== 24'hA5C33C) begin errors++; $display("FAIL first_key_rgb got %h exp a5c33c", key_rgb); end
        tick();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL first_key_pulse got %b exp 0", key_valid); end
        req = 2'b00;
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt [4];
        logic [23:0] exp_key;
        exp_gnt = '{2'b10, 2'b01, 2'b10, 2'b01};
        for (int i = 1; i <= 4; i++) begin
            set_key(24'h010101 * 24'(i));
            tick();
            gen_key_ready = 1'b0;
        end
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_key = 24'h010101 * 24'(i + 1);
            checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL rr_valid%0d got %b exp 1", i, key_valid); end
            checks++; if (gnt !== exp_gnt[i]) begin errors++; $display("FAIL rr_gnt%0d got %b exp %b", i, gnt, exp_gnt[i]); end
            checks++; if (key_rgb !== exp_key) begin errors++; $display("FAIL rr_key%0d got %h exp %h", i, key_rgb, exp_key); end
        end
        tick();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rr_empty got %b exp 0", key_valid); end
        req = 2'b00;
    endtask

    task automatic test_drop();
        for (int i = 1; i <= 6; i++) begin
            set_key(24'h100000 + 24'(i));
            tick();
            gen_key_ready = 1'b0;
        end
        checks++; if (drop_count !== EXP_DROP) begin errors++; $display("FAIL drop_count got %0d exp %0d", drop_count, EXP_DROP); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL drop_no_req got %b exp 0", key_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [23:0] exp_keys [5];
        exp_keys = '{24'h100001, 24'h100002, 24'h100003, 24'h100004, 24'h200000};
        req = 2'b01;
        set_key(24'h200000);
        tick();
        gen_key_ready = 1'b0;
        checks++; if (drop_count !== EXP_DROP) begin errors++; $display("FAIL fullpp_drop got %0d exp %0d", drop_count, EXP_DROP); end
        for (int i = 0; i < 5; i++) begin
            if (i != 0) tick();
            checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL fullpp_valid%0d got %b exp 1", i, key_valid); end
            checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL fullpp_gnt%0d got %b exp 01", i, gnt); end
            checks++; if (key_rgb !== exp_keys[i]) begin errors++; $display("FAIL fullpp_key%0d got %h exp %h", i, key_rgb, exp_keys[i]); end
        end
        tick();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL fullpp_empty got %b exp 0", key_valid); end
        req = 2'b00;
    endtask

    task automatic test_reseed();
        for (int i = 1; i <= 3; i++) begin
            set_key(24'h300000 + 24'(i));
            tick();
            gen_key_ready = 1'b0;
        end
        reseed_req = 1'b1;
        tick();
        reseed_req = 1'b0;
        req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) tick();
            checks++; if (gen_rst !== (i < 2)) begin errors++; $display("FAIL reseed_gen_rst%0d got %b exp %b", i, gen_rst, (i < 2)); end
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reseed_flush%0d got %b exp 0", i, key_valid); end
        end
        for (int j = 0; j < 2; j++) begin
            set_key(24'h3F3F3F);
            tick();
            gen_key_ready = 1'b0;
            checks++; if (reseed_ack !== (j == 1)) begin errors++; $display("FAIL reseed_ack%0d got %b exp %b", j, reseed_ack, (j == 1)); end
            checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reseed_warm%0d got %b exp 0", j, key_valid); end
        end
        tick();
        checks++; if (reseed_ack !== 1'b0) begin errors++; $display("FAIL reseed_ack_pulse got %b exp 0", reseed_ack); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reseed_no_stale got %b exp 0", key_valid); end
        set_key(24'hABCDEF);
        tick();
        gen_key_ready = 1'b0;
        tick();
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL reseed_fresh_valid got %b exp 1", key_valid); end
        checks++; if (key_rgb !== 24'hABCDEF) begin errors++; $display("FAIL reseed_fresh_key got %h exp abcdef", key_rgb); end
        req = 2'b00;
        tick();
    endtask

    task automatic test_reset_midstream();
        for (int i = 1; i <= 2; i++) begin
            set_key(24'h400000 + 24'(i));
            tick();
            gen_key_ready = 1'b0;
        end
        req = 2'b11;
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL mid_gnt0 got %b exp 10", gnt); end
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mid_gnt1 got %b exp 01", gnt); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 2'b00;
        checks++; if (gen_rst !== 1'b1) begin errors++; $display("FAIL mid_rst_gen_rst got %b exp 1", gen_rst); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL mid_rst_gnt got %b exp 00", gnt); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", key_valid); end
        checks++; if (key_rgb !== 24'h0) begin errors++; $display("FAIL mid_rst_key got %h exp 000000", key_rgb); end
        checks++; if (drop_count !== 8'd0) begin errors++; $display("FAIL mid_rst_drop got %0d exp 0", drop_count); end
        tick();
        tick();
        checks++; if (gen_rst !== 1'b0) begin errors++; $display("FAIL mid_rst_gen_rst_end got %b exp 0", gen_rst); end
        for (int j = 0; j < 2; j++) begin
            set_key(24'h3F3F3F);
            tick();
            gen_key_ready = 1'b0;
            checks++; if (reseed_ack !== 1'b0) begin errors++; $display("FAIL mid_no_ack%0d got %b exp 0", j, reseed_ack); end
        end
        for (int i = 1; i <= 2; i++) begin
            set_key(24'h500000 + 24'(i));
            tick();
            gen_key_ready = 1'b0;
        end
        req = 2'b11;
        tick();
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL mid_rr_first got %b exp 01", gnt); end
        checks++; if (key_rgb !== 24'h500001) begin errors++; $display("FAIL mid_rr_key0 got %h exp 500001", key_rgb); end
        tick();
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL mid_rr_second got %b exp 10", gnt); end
        checks++; if (key_rgb !== 24'h500002) begin errors++; $display("FAIL mid_rr_key1 got %h exp 500002", key_rgb); end
        tick();
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL mid_rr_empty got %b exp 0", key_valid); end
        req = 2'b00;
    endtask

    initial begin
        test_reset();
        test_warmup_first_key();
        test_round_robin();
        test_drop();
        test_full_push_pop();
        test_reseed();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
